regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file for the pipelined core, with a

---
 rtl/riscv_rf_pkg.sv | 9 +
 rtl/rf_scoreboard.sv | 33 +++
 rtl/regfile_mp.sv | 64 ++++++
 tb/tb_regfile_mp.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_rf_pkg.sv
// riscv_rf_pkg: shared register-file constants and types
package riscv_rf_pkg;
    localparam int RF_XLEN  = 32;
    localparam int RF_NREGS = 32;
    localparam int RF_AW    = $clog2(RF_NREGS);
    typedef logic [RF_AW-1:0]   rf_addr_t;
    typedef logic [RF_XLEN-1:0] rf_data_t;
    localparam rf_addr_t ZERO_ADDR = '0;
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write bits, set on issue, cleared on writeback
module rf_scoreboard
    import riscv_rf_pkg::*;
#(
    parameter int NREGS    = RF_NREGS,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    output logic [NREGS-1:0]  busy_vec
);
    localparam logic [NREGS-1:0] ZMASK = (ZERO_REG != 0) ? NREGS'(1) : '0;
    logic [NREGS-1:0] set_v, clr_v;
    // decode the issue destination and every writeback address into one-hot masks
    always_comb begin
        set_v = '0;
        clr_v = '0;
        if (iss_en) set_v[iss_addr] = 1'b1;
        for (int j = 0; j < NWR; j++)
            if (wr_en[j]) clr_v[wr_addr[j*AW +: AW]] = 1'b1;
    end
    // set dominates clear so a newly issued producer is never lost to an older writeback
    always_ff @(posedge clk) begin
        if (rst) busy_vec <= '0;
        else     busy_vec <= ((busy_vec & ~clr_v) | set_v) & ~ZMASK;
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write bypass and issue scoreboard
module regfile_mp
    import riscv_rf_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int NREGS    = RF_NREGS,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic [NREGS-1:0]    busy_vec
);
    logic [XLEN-1:0] mem [NREGS];

    rf_scoreboard #(.NREGS(NREGS), .NWR(NWR), .ZERO_REG(ZERO_REG)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .busy_vec (busy_vec)
    );

    // later ports are assigned last, so the highest-index port wins on an address clash
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) mem[r] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && !(ZERO_REG != 0 && wr_addr[j*AW +: AW] == '0))
                    mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] val;
        logic            zr;
        assign ra = rd_addr[i*AW +: AW];
        assign zr = (ZERO_REG != 0) && (ra == '0);
        // forward same-cycle write data, scanning upward so the highest matching port wins
        always_comb begin
            val = mem[ra];
            for (int j = 0; j < NWR; j++)
                if (BYPASS != 0 && !rst && wr_en[j] && wr_addr[j*AW +: AW] == ra)
                    val = wr_data[j*XLEN +: XLEN];
        end
        assign rd_data[i*XLEN +: XLEN] = zr ? '0 : val;
        assign rd_busy[i] = zr ? 1'b0 : busy_vec[ra];
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: two configurations driven in lockstep against a reference model
module tb_regfile_mp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  ra [3];
    logic [1:0]  we;
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic        ie;
    logic [4:0]  ia;

    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [9:0]  a_wr_addr;
    logic [63:0] a_wr_data;
    logic [31:0] a_busy_vec;
    logic [11:0] b_rd_addr;
    logic [95:0] b_rd_data;
    logic [2:0]  b_rd_busy;
    logic [7:0]  b_wr_addr;
    logic [63:0] b_wr_data;
    logic [3:0]  b_iss_addr;
    logic [15:0] b_busy_vec;

    assign a_rd_addr  = {ra[1], ra[0]};
    assign a_wr_addr  = {wa[1], wa[0]};
    assign a_wr_data  = {wd[1], wd[0]};
    assign b_rd_addr  = {ra[2][3:0], ra[1][3:0], ra[0][3:0]};
    assign b_wr_addr  = {wa[1][3:0], wa[0][3:0]};
    assign b_wr_data  = {wd[1], wd[0]};
    assign b_iss_addr = ia[3:0];

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wr_en(we), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .iss_en(ie), .iss_addr(ia), .busy_vec(a_busy_vec)
    );

    regfile_mp #(.XLEN(32), .NREGS(16), .NRD(3), .NWR(2), .ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(we), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .iss_en(ie), .iss_addr(b_iss_addr), .busy_vec(b_busy_vec)
    );

    int checks = 0;
    int errors = 0;
    string tag = "";

    logic [31:0] m_mem [2][32];
    logic [31:0] m_busy [2];
    int nregs [2] = '{32, 16};
    int nrd   [2] = '{2, 3};
    int zr    [2] = '{1, 0};
    int byp   [2] = '{1, 0};

    typedef struct { string n; logic [31:0] v; } exp_t;
    exp_t q [$];

    function automatic logic [4:0] msk(int k, logic [4:0] a);
        return a & 5'(nregs[k] - 1);
    endfunction

    function automatic logic [31:0] exp_v(int k, int kind, int i);
        logic [4:0]  a;
        logic [31:0] v;
        if (kind == 2) return m_busy[k];
        a = msk(k, ra[i]);
        if (zr[k] != 0 && a == 5'd0) return 32'd0;
        if (kind == 1) return {31'd0, m_busy[k][a]};
        v = m_mem[k][a];
        if (byp[k] != 0 && !rst)
            for (int j = 0; j < 2; j++)
                if (we[j] && msk(k, wa[j]) == a) v = wd[j];
        return v;
    endfunction

    function automatic logic [31:0] obs_v(int k, int kind, int i);
        if (k == 0)
            return kind == 0 ? a_rd_data[i*32 +: 32] : kind == 1 ? {31'd0, a_rd_busy[i]} : a_busy_vec;
        return kind == 0 ? b_rd_data[i*32 +: 32] : kind == 1 ? {31'd0, b_rd_busy[i]} : {16'd0, b_busy_vec};
    endfunction

    task automatic model_update();
        logic [31:0] nb;
        logic [4:0]  a;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int r = 0; r < 32; r++) m_mem[k][r] = 32'd0;
                m_busy[k] = 32'd0;
            end else begin
                nb = m_busy[k];
                for (int j = 0; j < 2; j++) begin
                    a = msk(k, wa[j]);
                    if (we[j]) begin
                        nb[a] = 1'b0;
                        if (!(zr[k] != 0 && a == 5'd0)) m_mem[k][a] = wd[j];
                    end
                end
                if (ie) nb[msk(k, ia)] = 1'b1;
                if (zr[k] != 0) nb[0] = 1'b0;
                m_busy[k] = nb;
            end
        end
    endtask

    task automatic idle();
        rst = 1'b0; we = 2'b00; ie = 1'b0; ia = 5'd0;
        for (int j = 0; j < 2; j++) begin wa[j] = 5'd0; wd[j] = 32'd0; end
    endtask

    task automatic cyc(input bit chk);
        exp_t e;
        logic [31:0] o;
        if (chk) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < nrd[k]; i++) begin
                    q.push_back('{$sformatf("%s cfg%0d rd_data[%0d]", tag, k, i), exp_v(k, 0, i)});
                    q.push_back('{$sformatf("%s cfg%0d rd_busy[%0d]", tag, k, i), exp_v(k, 1, i)});
                end
                q.push_back('{$sformatf("%s cfg%0d busy_vec", tag, k), exp_v(k, 2, 0)});
            end
        end
        #1;
        if (chk) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < nrd[k]; i++) begin
                    for (int kind = 0; kind < 2; kind++) begin
                        e = q.pop_front();
                        o = obs_v(k, kind, i);
                        checks++;
                        if (o !== e.v) begin
                            errors++;
                            $display("FAIL %s got %h expected %h", e.n, o, e.v);
                        end
                    end
                end
                e = q.pop_front();
                o = obs_v(k, 2, 0);
                checks++;
                if (o !== e.v) begin
                    errors++;
                    $display("FAIL %s got %h expected %h", e.n, o, e.v);
                end
            end
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        tag = "reset";
        idle(); for (int i = 0; i < 3; i++) ra[i] = 5'd0;
        rst = 1'b1; cyc(0);
        idle(); we = 2'b01; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF; cyc(1);
        idle(); ra[0] = 5'd5; cyc(1);
        rst = 1'b1; cyc(1);
        idle(); #1;
        checks++;
        if (a_rd_data[31:0] !== 32'd0) begin errors++; $display("FAIL reset_r5_a got %h expected %h", a_rd_data[31:0], 32'd0); end
        checks++;
        if (b_rd_data[31:0] !== 32'd0) begin errors++; $display("FAIL reset_r5_b got %h expected %h", b_rd_data[31:0], 32'd0); end
        checks++;
        if (a_busy_vec !== 32'd0) begin errors++; $display("FAIL reset_busy_a got %h expected %h", a_busy_vec, 32'd0); end
        cyc(1);
    endtask

    task automatic test_zero_reg();
        tag = "zero";
        idle(); ra[0] = 5'd0;
        we = 2'b01; wa[0] = 5'd0; wd[0] = 32'h1234; ie = 1'b1; ia = 5'd0; cyc(1);
        idle(); ra[0] = 5'd0; #1;
        checks++;
        if (a_rd_data[31:0] !== 32'd0) begin errors++; $display("FAIL zero_rd_a got %h expected %h", a_rd_data[31:0], 32'd0); end
        checks++;
        if (a_rd_busy[0] !== 1'b0 || a_busy_vec[0] !== 1'b0) begin errors++; $display("FAIL zero_busy_a got %b/%b expected 0/0", a_rd_busy[0], a_busy_vec[0]); end
        checks++;
        if (b_rd_data[31:0] !== 32'h1234) begin errors++; $display("FAIL zero_rd_b got %h expected %h", b_rd_data[31:0], 32'h1234); end
        cyc(1);
    endtask

    task automatic test_bypass();
        tag = "bypass";
        idle(); ra[1] = 5'd7; we = 2'b01; wa[0] = 5'd7; wd[0] = 32'hA5A5A5A5; #1;
        checks++;
        if (a_rd_data[63:32] !== 32'hA5A5A5A5) begin errors++; $display("FAIL bypass_a got %h expected %h", a_rd_data[63:32], 32'hA5A5A5A5); end
        checks++;
        if (b_rd_data[63:32] !== 32'd0) begin errors++; $display("FAIL nobypass_old_b got %h expected %h", b_rd_data[63:32], 32'd0); end
        cyc(1);
        idle(); ra[1] = 5'd7; #1;
        checks++;
        if (b_rd_data[63:32] !== 32'hA5A5A5A5) begin errors++; $display("FAIL nobypass_new_b got %h expected %h", b_rd_data[63:32], 32'hA5A5A5A5); end
        cyc(1);
    endtask

    task automatic test_priority();
        tag = "priority";
        idle(); ra[0] = 5'd3; we = 2'b11; wa[0] = 5'd3; wa[1] = 5'd3; wd[0] = 32'h1; wd[1] = 32'h2; #1;
        checks++;
        if (a_rd_data[31:0] !== 32'h2) begin errors++; $display("FAIL prio_bypass_a got %h expected %h", a_rd_data[31:0], 32'h2); end
        cyc(1);
        idle(); ra[0] = 5'd3; #1;
        checks++;
        if (a_rd_data[31:0] !== 32'h2) begin errors++; $display("FAIL prio_store_a got %h expected %h", a_rd_data[31:0], 32'h2); end
        checks++;
        if (b_rd_data[31:0] !== 32'h2) begin errors++; $display("FAIL prio_store_b got %h expected %h", b_rd_data[31:0], 32'h2); end
        cyc(1);
    endtask

    task automatic test_scoreboard();
        tag = "scoreboard";
        idle(); ra[0] = 5'd9; ie = 1'b1; ia = 5'd9; #1;
        checks++;
        if (a_rd_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_issue_same_cycle got %b expected 0", a_rd_busy[0]); end
        cyc(1);
        idle(); ra[0] = 5'd9; we = 2'b01; wa[0] = 5'd9; wd[0] = 32'h99; ie = 1'b1; ia = 5'd9; #1;
        checks++;
        if (a_busy_vec[9] !== 1'b1 || a_rd_busy[0] !== 1'b1 || b_busy_vec[9] !== 1'b1) begin errors++; $display("FAIL sb_set got %b%b%b expected 111", a_busy_vec[9], a_rd_busy[0], b_busy_vec[9]); end
        cyc(1);
        idle(); ra[0] = 5'd9; we = 2'b01; wa[0] = 5'd9; wd[0] = 32'h98; #1;
        checks++;
        if (a_busy_vec[9] !== 1'b1 || a_rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_set_wins got %b%b expected 11", a_busy_vec[9], a_rd_busy[0]); end
        cyc(1);
        idle(); ra[0] = 5'd9; #1;
        checks++;
        if (a_busy_vec[9] !== 1'b0 || a_rd_busy[0] !== 1'b0 || b_rd_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_clear got %b%b%b expected 000", a_busy_vec[9], a_rd_busy[0], b_rd_busy[0]); end
        cyc(1);
    endtask

    task automatic test_random();
        tag = "random";
        for (int n = 0; n < 3000; n++) begin
            bit narrow;
            narrow = ($urandom_range(0, 1) == 0);
            rst = ($urandom_range(0, 49) == 0);
            we = 2'($urandom_range(0, 3));
            ie = ($urandom_range(0, 2) == 0);
            ia = 5'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
            for (int j = 0; j < 2; j++) begin
                wa[j] = 5'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
                wd[j] = $urandom;
            end
            for (int i = 0; i < 3; i++) ra[i] = 5'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
            cyc(1);
        end
    endtask

    initial begin
        idle();
        for (int i = 0; i < 3; i++) ra[i] = 5'd0;
        @(negedge clk);
        test_reset();
        test_zero_reg();
        test_bypass();
        test_priority();
        test_scoreboard();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
